axis_processor_arbiter: RTL and testbench

- Shares one axis_processor instance between NUM_CH independent AXI-Stream requesters.
- Grants the processor to one channel for a whole "session": that channel's command words pass through up to and including a RUN command, then exactly the run's output words are routed back to that channel.
- Grant then rotates round-robin.
- Sits between host-side channel adapters and the processor's s_axis/m_axis ports.

---
 rtl/axis_processor_arbiter_pkg.sv | 33 +++
 rtl/axis_processor_arbiter_rr_picker.sv | 39 +++
 rtl/axis_processor_arbiter.sv | 132 +++++++++++++
 tb/tb_axis_processor_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_processor_arbiter_pkg.sv
// Shared definitions for the AXI-Stream processor arbiter: session states,
// the RUN opcode and helpers that split a command word into opcode/payload.
package processor_arbiter_config;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] OPC_RUN = 3'd1;

  // Helpers work on a zero-extended word so any word width up to this fits.
  localparam int WORD_MAX = 64;

  // Top opc_width bits of an inp_width-bit word.
  function automatic logic [WORD_MAX-1:0] opc_of(input logic [WORD_MAX-1:0] word,
                                                 input int inp_width,
                                                 input int opc_width);
    logic [WORD_MAX-1:0] mask;
    mask = (WORD_MAX'(1) << opc_width) - WORD_MAX'(1);
    return (word >> (inp_width - opc_width)) & mask;
  endfunction

  // Low run_width bits of a word (run-length payload of a RUN command).
  function automatic logic [WORD_MAX-1:0] run_len_of(input logic [WORD_MAX-1:0] word,
                                                     input int run_width);
    logic [WORD_MAX-1:0] mask;
    mask = (WORD_MAX'(1) << run_width) - WORD_MAX'(1);
    return word & mask;
  endfunction

endpackage

// File: rtl/axis_processor_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: returns the first requester
// found when searching ptr, ptr+1, ... modulo N.
module rr_picker #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any_req
);

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  // Rotate the request vector so that bit 0 corresponds to ptr.
  assign req2 = {req, req};
  assign rot  = N'(req2 >> ptr);

  // Lowest set bit of the rotated vector, mapped back to a channel index.
  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k[IW-1:0]]) begin
        off = k[IW-1:0];
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW+1)'(N)) begin
      grant = IW'(sum - (IW+1)'(N));
    end else begin
      grant = IW'(sum);
    end
    any_req = |req;
  end

endmodule

// File: rtl/axis_processor_arbiter.sv
// Shares one axis_processor between NUM_CH AXI-Stream requesters. A channel
// owns the processor for a session: its commands up to and including a RUN,
// then exactly RUN-length output words routed back to it.
module axis_processor_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int INP_WIDTH = 8,
  parameter int OUT_WIDTH = 8,
  parameter int OPC_WIDTH = 3,
  parameter logic [OPC_WIDTH-1:0] OPC_RUN = OPC_WIDTH'(processor_arbiter_config::OPC_RUN),
  parameter int RUN_WIDTH = INP_WIDTH - OPC_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*INP_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_CH-1:0]             s_axis_tvalid,
  output logic [NUM_CH-1:0]             s_axis_tready,
  output logic [NUM_CH*OUT_WIDTH-1:0]   m_axis_tdata,
  output logic [NUM_CH-1:0]             m_axis_tvalid,
  input  logic [NUM_CH-1:0]             m_axis_tready,
  output logic [INP_WIDTH-1:0]          proc_s_axis_tdata,
  output logic                          proc_s_axis_tvalid,
  input  logic                          proc_s_axis_tready,
  input  logic [OUT_WIDTH-1:0]          proc_m_axis_tdata,
  input  logic                          proc_m_axis_tvalid,
  output logic                          proc_m_axis_tready,
  output logic [$clog2(NUM_CH)-1:0]     owner,
  output logic                          busy
);

  import processor_arbiter_config::state_t;
  import processor_arbiter_config::IDLE;
  import processor_arbiter_config::FWD;
  import processor_arbiter_config::DRAIN;
  import processor_arbiter_config::WORD_MAX;
  import processor_arbiter_config::opc_of;
  import processor_arbiter_config::run_len_of;

  localparam int CW = $clog2(NUM_CH);

  state_t                 state_reg;
  logic [CW-1:0]          owner_reg;
  logic [CW-1:0]          rr_ptr_reg;
  logic [RUN_WIDTH-1:0]   remaining_reg;

  logic [INP_WIDTH-1:0]   cmd_word [NUM_CH];
  logic [INP_WIDTH-1:0]   owner_word;
  logic [CW-1:0]          pick_idx;
  logic [CW-1:0]          next_ptr;
  logic                   any_req;
  logic                   in_fwd;
  logic                   in_drain;
  logic                   routing;
  logic                   in_hs;
  logic                   out_hs;
  logic                   is_run;
  logic [RUN_WIDTH-1:0]   run_len;

  rr_picker #(.N(NUM_CH)) u_picker (
    .req     (s_axis_tvalid),
    .ptr     (rr_ptr_reg),
    .grant   (pick_idx),
    .any_req (any_req)
  );

  assign in_fwd   = (state_reg == FWD);
  assign in_drain = (state_reg == DRAIN);
  assign routing  = in_fwd | in_drain;
  assign busy     = routing;
  assign owner    = owner_reg;

  // Per-channel unpacking and demultiplexing; non-owners see idle interfaces.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign cmd_word[gi]      = s_axis_tdata[gi*INP_WIDTH +: INP_WIDTH];
    assign s_axis_tready[gi] = in_fwd && (owner_reg == CW'(gi)) && proc_s_axis_tready;
    assign m_axis_tvalid[gi] = routing && (owner_reg == CW'(gi)) && proc_m_axis_tvalid;
    assign m_axis_tdata[gi*OUT_WIDTH +: OUT_WIDTH] =
        (routing && (owner_reg == CW'(gi))) ? proc_m_axis_tdata : '0;
  end

  assign owner_word         = cmd_word[owner_reg];
  assign proc_s_axis_tdata  = owner_word;
  assign proc_s_axis_tvalid = in_fwd & s_axis_tvalid[owner_reg];
  // Outside a session the processor output is accepted and discarded.
  assign proc_m_axis_tready = routing ? m_axis_tready[owner_reg] : 1'b1;

  assign in_hs   = proc_s_axis_tvalid & proc_s_axis_tready;
  assign out_hs  = in_drain & proc_m_axis_tvalid & m_axis_tready[owner_reg];
  assign is_run  = (opc_of(WORD_MAX'(owner_word), INP_WIDTH, OPC_WIDTH) == WORD_MAX'(OPC_RUN));
  assign run_len = RUN_WIDTH'(run_len_of(WORD_MAX'(owner_word), RUN_WIDTH));
  assign next_ptr = (owner_reg == CW'(NUM_CH - 1)) ? '0 : owner_reg + CW'(1);

  // Session FSM: grant, forward commands until RUN, then count output words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_reg     <= '0;
      rr_ptr_reg    <= '0;
      remaining_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            owner_reg <= pick_idx;
            state_reg <= FWD;
          end
        end
        FWD: begin
          if (in_hs && is_run) begin
            remaining_reg <= run_len;
            if (run_len == '0) begin
              state_reg  <= IDLE;
              rr_ptr_reg <= next_ptr;
            end else begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_hs && (remaining_reg != '0)) begin
            remaining_reg <= remaining_reg - RUN_WIDTH'(1);
            if (remaining_reg == RUN_WIDTH'(1)) begin
              state_reg  <= IDLE;
              rr_ptr_reg <= next_ptr;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_processor_arbiter.sv
// Bench for axis_processor_arbiter: directed scenarios followed by random
// sessions, checked against a round-robin/session model kept here.
module tb_axis_processor_arbiter;

  localparam int N   = 4;
  localparam int IW  = 8;
  localparam int OW  = 8;
  localparam int OPW = 3;
  localparam int RW  = IW - OPW;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*IW-1:0]   s_axis_tdata;
  logic [N-1:0]      s_axis_tvalid;
  logic [N-1:0]      s_axis_tready;
  logic [N*OW-1:0]   m_axis_tdata;
  logic [N-1:0]      m_axis_tvalid;
  logic [N-1:0]      m_axis_tready;
  logic [IW-1:0]     proc_s_axis_tdata;
  logic              proc_s_axis_tvalid;
  logic              proc_s_axis_tready;
  logic [OW-1:0]     proc_m_axis_tdata;
  logic              proc_m_axis_tvalid;
  logic              proc_m_axis_tready;
  logic [CW-1:0]     owner;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int model_rr = 0;
  logic [OW-1:0] out_q[$];

  always #5 clk = ~clk;

  axis_processor_arbiter #(
    .NUM_CH(N), .INP_WIDTH(IW), .OUT_WIDTH(OW), .OPC_WIDTH(OPW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .proc_s_axis_tdata  (proc_s_axis_tdata),
    .proc_s_axis_tvalid (proc_s_axis_tvalid),
    .proc_s_axis_tready (proc_s_axis_tready),
    .proc_m_axis_tdata  (proc_m_axis_tdata),
    .proc_m_axis_tvalid (proc_m_axis_tvalid),
    .proc_m_axis_tready (proc_m_axis_tready),
    .owner              (owner),
    .busy               (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] onehot(input int c);
    return N'(1) << c;
  endfunction

  function automatic logic [IW-1:0] mk(input int opc, input int len);
    return IW'((opc << RW) | (len & ((1 << RW) - 1)));
  endfunction

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] req);
    for (int k = 0; k < N; k++) begin
      if (req[(model_rr + k) % N]) return (model_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_word(input int ch, input logic [IW-1:0] w);
    s_axis_tdata[ch*IW +: IW] = w;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    s_axis_tvalid = '0;
    m_axis_tready = '0;
    proc_s_axis_tready = 1'b0;
    proc_m_axis_tvalid = 1'b0;
    tick;
    rst = 1'b0;
    model_rr = 0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_owner", 64'(owner), 64'd0);
    check("reset_p_m_tready", 64'(proc_m_axis_tready), 64'd1);
    $display("reset applied");
  endtask

  // Present requests in IDLE; one cycle later the model's choice must own the processor.
  task automatic do_grant(input logic [N-1:0] req, output int ch);
    int exp;
    exp = pick(req);
    for (int c = 0; c < N; c++) set_word(c, IW'($urandom));
    s_axis_tvalid = req;
    proc_m_axis_tvalid = 1'($urandom);
    proc_m_axis_tdata = OW'($urandom);
    m_axis_tready = N'($urandom);
    #1;
    check("idle_s_tready", 64'(s_axis_tready), 64'd0);
    check("idle_p_s_tvalid", 64'(proc_s_axis_tvalid), 64'd0);
    check("idle_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("idle_p_m_tready", 64'(proc_m_axis_tready), 64'd1);
    tick;
    proc_m_axis_tvalid = 1'b0;
    check("grant_owner", 64'(owner), 64'(exp));
    check("grant_busy", 64'(busy), 64'd1);
    $display("grant req=%b -> owner=%0d (expected %0d)", req, owner, exp);
    ch = exp;
  endtask

  // Offer one command word from the owner, holding processor ready low for 'stalls' cycles.
  task automatic send_word(input int ch, input logic [IW-1:0] w, input int stalls);
    int opc, len;
    opc = int'(w) >> RW;
    len = int'(w) & ((1 << RW) - 1);
    set_word(ch, w);
    s_axis_tvalid[ch] = 1'b1;
    proc_s_axis_tready = 1'b0;
    for (int i = 0; i < stalls; i++) begin
      #1;
      check("stall_s_tready", 64'(s_axis_tready), 64'd0);
      check("stall_p_s_tvalid", 64'(proc_s_axis_tvalid), 64'd1);
      tick;
    end
    proc_s_axis_tready = 1'b1;
    #1;
    check("fwd_s_tready", 64'(s_axis_tready), 64'(onehot(ch)));
    check("fwd_p_s_tdata", 64'(proc_s_axis_tdata), 64'(w));
    check("fwd_p_s_tvalid", 64'(proc_s_axis_tvalid), 64'd1);
    tick;
    s_axis_tvalid[ch] = 1'b0;
    proc_s_axis_tready = 1'($urandom);
    if (opc == 1 && len == 0) begin
      check("run0_busy", 64'(busy), 64'd0);
      model_rr = (ch + 1) % N;
    end else begin
      check("post_word_busy", 64'(busy), 64'd1);
      check("post_word_owner", 64'(owner), 64'(ch));
    end
    $display("cmd ch=%0d word=%02h opc=%0d stalls=%0d busy=%0d", ch, w, opc, stalls, busy);
  endtask

  // Deliver 'len' processor output words to the owner with backpressure and gaps.
  task automatic drain(input int ch, input int len, input int first_stall, input int max_stall);
    logic [OW-1:0] d;
    int st;
    for (int k = 0; k < len; k++) begin
      d = (out_q.size() > 0) ? out_q.pop_front() : OW'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        proc_m_axis_tvalid = 1'b0;
        m_axis_tready = '1;
        #1;
        check("gap_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        tick;
      end
      st = (k == 0) ? first_stall : int'($urandom_range(0, max_stall));
      proc_m_axis_tdata = d;
      proc_m_axis_tvalid = 1'b1;
      m_axis_tready = N'($urandom);
      m_axis_tready[ch] = 1'b0;
      for (int i = 0; i < st; i++) begin
        #1;
        check("bp_p_m_tready", 64'(proc_m_axis_tready), 64'd0);
        check("bp_m_tvalid", 64'(m_axis_tvalid), 64'(onehot(ch)));
        check("drain_s_tready", 64'(s_axis_tready), 64'd0);
        check("drain_p_s_tvalid", 64'(proc_s_axis_tvalid), 64'd0);
        tick;
        check("bp_busy", 64'(busy), 64'd1);
      end
      m_axis_tready[ch] = 1'b1;
      #1;
      check("out_p_m_tready", 64'(proc_m_axis_tready), 64'd1);
      check("out_m_tdata", 64'(m_axis_tdata), 64'(d) << (ch * OW));
      check("out_m_tvalid", 64'(m_axis_tvalid), 64'(onehot(ch)));
      tick;
      $display("out ch=%0d word=%02h (%0d of %0d) stalls=%0d", ch, d, k + 1, len, st);
      if (k < len - 1) check("drain_busy", 64'(busy), 64'd1);
    end
    proc_m_axis_tvalid = 1'b0;
    check("end_busy", 64'(busy), 64'd0);
    model_rr = (ch + 1) % N;
  endtask

  initial begin
    int ch;
    int nw, len, opc;
    logic [N-1:0] req;

    s_axis_tdata = '0;
    proc_m_axis_tdata = '0;
    do_reset;

    // Single session on ch1 with a stray output in FWD (routed, not counted).
    do_grant(4'b0010, ch);
    proc_m_axis_tdata = 8'h5C;
    proc_m_axis_tvalid = 1'b1;
    m_axis_tready = 4'b0010;
    #1;
    check("fwd_out_m_tvalid", 64'(m_axis_tvalid), 64'h2);
    check("fwd_out_m_tdata", 64'(m_axis_tdata), 64'h5C00);
    check("fwd_out_p_m_tready", 64'(proc_m_axis_tready), 64'd1);
    tick;
    proc_m_axis_tvalid = 1'b0;
    send_word(ch, mk(2, 7), 0);
    send_word(ch, mk(2, 3), 3);
    send_word(ch, mk(1, 3), 1);
    out_q.push_back(8'hA1);
    out_q.push_back(8'hA2);
    out_q.push_back(8'hA3);
    drain(ch, 3, 0, 1);
    // rr pointer now at 2: everyone requesting must pick ch2.
    do_grant(4'b1111, ch);
    send_word(ch, mk(1, 0), 0);

    // Contention between ch0 and ch2 from a fresh pointer.
    do_reset;
    do_grant(4'b0101, ch);
    send_word(ch, mk(1, 1), 0);
    drain(ch, 1, 0, 0);
    do_grant(4'b0101, ch);
    send_word(ch, mk(1, 2), 0);
    drain(ch, 2, 5, 0);

    // RUN of length zero from ch3 wraps the pointer to 0.
    do_grant(4'b1000, ch);
    send_word(ch, mk(4, 9), 0);
    send_word(ch, mk(1, 0), 0);
    do_grant(4'b1111, ch);
    send_word(ch, mk(1, 0), 0);

    // Reset in the middle of a drain.
    do_grant(4'b0100, ch);
    send_word(ch, mk(1, 4), 0);
    proc_m_axis_tdata = 8'h77;
    proc_m_axis_tvalid = 1'b1;
    m_axis_tready = '1;
    rst = 1'b1;
    tick;
    check("rst_drain_busy", 64'(busy), 64'd0);
    check("rst_drain_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_drain_owner", 64'(owner), 64'd0);
    rst = 1'b0;
    proc_m_axis_tvalid = 1'b0;
    model_rr = 0;
    $display("reset during drain");
    do_grant(4'b1000, ch);
    send_word(ch, mk(1, 1), 0);
    drain(ch, 1, 1, 0);

    // Random sessions.
    for (int s = 0; s < 40; s++) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      do_grant(req, ch);
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        opc = $urandom_range(0, 7);
        if (opc == 1) opc = 0;
        send_word(ch, mk(opc, $urandom), $urandom_range(0, 2));
      end
      len = $urandom_range(0, 4);
      send_word(ch, mk(1, len), $urandom_range(0, 1));
      if (len > 0) drain(ch, len, $urandom_range(0, 2), 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
